// File: rtl/lcd_table_renderer.sv
// Streams a snapshot of the 10x10 game table to a 64x64 KS0108 half-panel
// as page/column commands plus column data bytes over a valid/ready handshake.
module lcd_table_renderer #(
  parameter int CELL       = 6,
  parameter int BORDER_COL = 60
) (
  input  logic        clk_40M,
  input  logic        rst,
  input  logic [99:0] table_in,
  input  logic        frame_start,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_valid,
  input  logic        lcd_ready,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    CMD_PAGE,
    CMD_COL,
    DATA,
    DONE
  } state_t;

  state_t      state;
  logic [99:0] snapshot;
  logic [2:0]  page;
  logic [5:0]  x;
  logic        pending;
  logic        accept;
  logic        start_frame;

  assign accept      = lcd_valid && lcd_ready;
  assign start_frame = ((state == IDLE) && frame_start) ||
                       ((state == DONE) && (pending || frame_start));

  // One vertical byte of the panel: bit b is pixel row 8*pg + b in column col.
  function automatic logic [7:0] pixel_byte(input logic [99:0] snap,
                                            input logic [2:0]  pg,
                                            input logic [5:0]  col);
    logic [7:0] bits;
    int         y;
    int         xi;
    bits = '0;
    xi   = int'(col);
    for (int b = 0; b < 8; b++) begin
      y = 8 * int'(pg) + b;
      if (y < 10 * CELL) begin
        if (xi == BORDER_COL)
          bits[b] = 1'b1;
        else if (xi < 10 * CELL)
          bits[b] = snap[(y / CELL) * 10 + xi / CELL] &&
                    (xi % CELL != CELL - 1) && (y % CELL != CELL - 1);
      end
    end
    return bits;
  endfunction

  // NOTE: the snapshot is pure datapath that is always loaded before it is read,
  // so it has no reset; keeping it out of the reset tree keeps that tree small.
  always_ff @(posedge clk_40M) begin
    if (start_frame) snapshot <= table_in;
  end

  // NOTE: every state and output register uses non-blocking assignments, so the
  // order of statements below never changes which value another branch sees.
  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      page       <= '0;
      x          <= '0;
      pending    <= 1'b0;
      lcd_data   <= 8'h00;
      lcd_rs     <= 1'b0;
      lcd_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start && busy) pending <= 1'b1;

      if (start_frame) begin
        state     <= CMD_PAGE;
        page      <= '0;
        pending   <= 1'b0;
        lcd_data  <= 8'hB8;
        lcd_rs    <= 1'b0;
        lcd_valid <= 1'b1;
        busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          CMD_PAGE: begin
            if (accept) begin
              state    <= CMD_COL;
              lcd_data <= 8'h40;
            end
          end
          CMD_COL: begin
            if (accept) begin
              state    <= DATA;
              x        <= '0;
              lcd_data <= pixel_byte(snapshot, page, 6'd0);
              lcd_rs   <= 1'b1;
            end
          end
          DATA: begin
            if (accept) begin
              if (x == 6'd63) begin
                lcd_rs <= 1'b0;
                if (page == 3'd7) begin
                  state      <= DONE;
                  lcd_data   <= 8'h00;
                  lcd_valid  <= 1'b0;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                end else begin
                  state    <= CMD_PAGE;
                  page     <= page + 3'd1;
                  lcd_data <= {5'b10111, page + 3'd1};
                end
              end else begin
                x        <= x + 6'd1;
                lcd_data <= pixel_byte(snapshot, page, x + 6'd1);
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_table_renderer.sv
// Self-checking bench for lcd_table_renderer: bitmap-based scoreboard of every
// accepted byte, spot-check vector table, and reset/back-to-back sequences.
module tb_lcd_table_renderer;

  logic        clk_40M = 1'b0;
  logic        rst;
  logic [99:0] table_in;
  logic        frame_start;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_valid;
  logic        lcd_ready;
  logic        busy;
  logic        frame_done;

  lcd_table_renderer dut (
    .clk_40M    (clk_40M),
    .rst        (rst),
    .table_in   (table_in),
    .frame_start(frame_start),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_valid  (lcd_valid),
    .lcd_ready  (lcd_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk_40M = ~clk_40M;

  typedef struct {
    logic [99:0] tbl;
    int          pct;
    int          idx;
    logic [8:0]  exp;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  int         acc_cnt = 0;
  int         done_cnt = 0;
  int         ready_pct = 100;
  logic [8:0] exp_q[$];
  logic [8:0] cap_q[$];
  logic       prev_stall = 1'b0;
  logic [9:0] prev_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Expected frame built from a rendered 64x64 image, then sliced into bytes.
  task automatic push_frame(input logic [99:0] t);
    bit         img[64][64];
    logic [7:0] byte_v;
    for (int y = 0; y < 64; y++)
      for (int xx = 0; xx < 64; xx++) img[y][xx] = 1'b0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        if (t[r*10+c])
          for (int dy = 0; dy < 5; dy++)
            for (int dx = 0; dx < 5; dx++) img[r*6+dy][c*6+dx] = 1'b1;
    for (int y = 0; y < 60; y++) img[y][60] = 1'b1;
    for (int p = 0; p < 8; p++) begin
      exp_q.push_back({1'b0, 8'hB8 + 8'(p)});
      exp_q.push_back(9'h040);
      for (int xx = 0; xx < 64; xx++) begin
        for (int b = 0; b < 8; b++) byte_v[b] = img[8*p+b][xx];
        exp_q.push_back({1'b1, byte_v});
      end
    end
  endtask

  // Random backpressure source, changed just after each rising edge.
  initial begin
    lcd_ready = 1'b1;
    forever begin
      @(posedge clk_40M);
      #1;
      lcd_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: scoreboard pop on every transfer, stall stability, busy/valid tie.
  always @(negedge clk_40M) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {22'd0, lcd_valid, lcd_rs, lcd_data}, {22'd0, prev_word});
      check("busy_vs_valid", {31'd0, busy}, {31'd0, lcd_valid});
      if (lcd_valid && lcd_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", exp_q.size(), 1);
        end else begin
          check($sformatf("byte%0d", acc_cnt), {23'd0, lcd_rs, lcd_data}, {23'd0, exp_q.pop_front()});
        end
        cap_q.push_back({lcd_rs, lcd_data});
        acc_cnt++;
      end
      if (frame_done) done_cnt++;
      prev_stall = lcd_valid && !lcd_ready;
      prev_word  = {1'b1, lcd_rs, lcd_data};
    end
  end

  task automatic pulse_start();
    @(posedge clk_40M);
    #1 frame_start = 1'b1;
    @(posedge clk_40M);
    #1 frame_start = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    while (acc_cnt < n && k < 20000) begin
      @(negedge clk_40M);
      k++;
    end
    if (acc_cnt < n) check("timeout_bytes", acc_cnt, n);
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (done_cnt < n && k < 20000) begin
      @(negedge clk_40M);
      k++;
    end
    if (done_cnt < n) check("timeout_done", done_cnt, n);
  endtask

  task automatic run_frame(input logic [99:0] t, input int pct);
    int d0;
    ready_pct = pct;
    d0 = done_cnt;
    @(posedge clk_40M);
    #1 table_in = t;
    cap_q.delete();
    push_frame(t);
    pulse_start();
    wait_done(d0 + 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  function automatic vec_t mk(input logic [99:0] t, input int pct, input int idx, input logic [8:0] e);
    vec_t v;
    v.tbl = t;
    v.pct = pct;
    v.idx = idx;
    v.exp = e;
    return v;
  endfunction

  initial begin
    vec_t        vecs[$];
    logic [99:0] last_tbl;
    int          last_pct;
    int          n_done;
    int          a0;
    int          d0;
    logic [127:0] rnd;
    logic [99:0]  t_rand;

    // Spot values: index = page*66 + 2 + x for data, page*66 for the page command.
    vecs.push_back(mk(100'd0, 100, 0, 9'h0B8));
    vecs.push_back(mk(100'd0, 100, 1, 9'h040));
    vecs.push_back(mk(100'd0, 100, 2, 9'h100));
    vecs.push_back(mk(100'd0, 100, 2 + 60, 9'h1FF));
    vecs.push_back(mk(100'd0, 100, 7*66, 9'h0BF));
    vecs.push_back(mk(100'd0, 100, 7*66 + 2 + 60, 9'h10F));
    vecs.push_back(mk(100'd0, 100, 7*66 + 2 + 63, 9'h100));
    vecs.push_back(mk(100'd1, 100, 2 + 0, 9'h11F));
    vecs.push_back(mk(100'd1, 100, 2 + 4, 9'h11F));
    vecs.push_back(mk(100'd1, 100, 2 + 5, 9'h100));
    vecs.push_back(mk(100'd1, 100, 66 + 2, 9'h100));
    vecs.push_back(mk(100'd1 << 10, 100, 2 + 0, 9'h1C0));
    vecs.push_back(mk(100'd1 << 10, 100, 2 + 5, 9'h100));
    vecs.push_back(mk(100'd1 << 10, 100, 66 + 2 + 0, 9'h107));
    vecs.push_back(mk(100'd1 << 10, 100, 66 + 2 + 4, 9'h107));
    vecs.push_back(mk(100'd1 << 99, 100, 6*66 + 2 + 53, 9'h100));
    vecs.push_back(mk(100'd1 << 99, 100, 6*66 + 2 + 54, 9'h1C0));
    vecs.push_back(mk(100'd1 << 99, 100, 6*66 + 2 + 58, 9'h1C0));
    vecs.push_back(mk(100'd1 << 99, 100, 7*66 + 2 + 54, 9'h107));
    vecs.push_back(mk(100'd1 << 99, 100, 7*66 + 2 + 59, 9'h100));
    vecs.push_back(mk(100'd1 << 99, 30, 6*66 + 2 + 56, 9'h1C0));
    vecs.push_back(mk(100'd1 << 99, 30, 7*66 + 2 + 60, 9'h10F));

    rst = 1'b1;
    frame_start = 1'b0;
    table_in = '0;
    repeat (3) @(negedge clk_40M);
    check("rst_valid", {31'd0, lcd_valid}, 0);
    check("rst_data", {24'd0, lcd_data}, 0);
    check("rst_rs", {31'd0, lcd_rs}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, frame_done}, 0);
    @(posedge clk_40M);
    #1 rst = 1'b0;

    // Empty table, ready always high: latency and exact frame length.
    @(posedge clk_40M);
    #1 table_in = '0;
    cap_q.delete();
    push_frame('0);
    frame_start = 1'b1;
    @(posedge clk_40M);
    #1 frame_start = 1'b0;
    n_done = 0;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk_40M);
      if (n == 1) begin
        check("first_valid", {31'd0, lcd_valid}, 1);
        check("first_busy", {31'd0, busy}, 1);
        check("first_byte", {23'd0, lcd_rs, lcd_data}, 32'h0B8);
      end
      if (frame_done) begin
        n_done = n;
        break;
      end
    end
    check("done_cycle", n_done, 529);
    @(negedge clk_40M);
    check("done_one_cycle", {31'd0, frame_done}, 0);
    check("idle_after_done", {31'd0, lcd_valid}, 0);
    check("frame_bytes", cap_q.size(), 528);
    check("queue_drained", exp_q.size(), 0);

    // Table-driven spot values; one frame per distinct table/ready setting.
    last_tbl = '0;
    last_pct = -1;
    foreach (vecs[i]) begin
      if (i == 0 || vecs[i].tbl !== last_tbl || vecs[i].pct != last_pct) begin
        run_frame(vecs[i].tbl, vecs[i].pct);
        last_tbl = vecs[i].tbl;
        last_pct = vecs[i].pct;
      end
      if (cap_q.size() > vecs[i].idx)
        check($sformatf("vec%0d_idx%0d", i, vecs[i].idx), {23'd0, cap_q[vecs[i].idx]}, {23'd0, vecs[i].exp});
      else
        check($sformatf("vec%0d_short", i), cap_q.size(), vecs[i].idx + 1);
    end

    // Backpressure with a random table: scoreboard compares every byte.
    rnd = {$urandom, $urandom, $urandom, $urandom};
    t_rand = rnd[99:0];
    run_frame(t_rand, 30);
    check("bp_frame_bytes", cap_q.size(), 528);

    // Snapshot isolation and collapsed pending requests.
    ready_pct = 100;
    a0 = acc_cnt;
    d0 = done_cnt;
    @(posedge clk_40M);
    #1 table_in = t_rand;
    push_frame(t_rand);
    pulse_start();
    wait_acc(a0 + 100);
    @(posedge clk_40M);
    #1 table_in = '1;
    push_frame('1);
    pulse_start();
    wait_acc(a0 + 150);
    pulse_start();
    wait_acc(a0 + 200);
    pulse_start();
    wait_done(d0 + 2);
    repeat (50) @(negedge clk_40M);
    check("extra_frames", done_cnt - d0, 2);
    check("extra_bytes", acc_cnt - a0, 1056);
    check("extra_idle", {31'd0, lcd_valid}, 0);
    check("queue_drained_b2b", exp_q.size(), 0);

    // Asynchronous reset mid-frame, with a pending request outstanding.
    table_in = '0;
    a0 = acc_cnt;
    push_frame('0);
    pulse_start();
    wait_acc(a0 + 300);
    pulse_start();
    d0 = done_cnt;
    @(posedge clk_40M);
    #2 rst = 1'b1;
    #1;
    check("abort_valid", {31'd0, lcd_valid}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk_40M);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk_40M);
    check("pending_cleared", {31'd0, lcd_valid}, 0);
    check("no_done_on_abort", done_cnt, d0);
    run_frame('0, 100);
    if (cap_q.size() > 0) check("restart_first", {23'd0, cap_q[0]}, 32'h0B8);
    else check("restart_short", cap_q.size(), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
